// File: rtl/seg7_pkg.sv
// seg7_pkg: shared definitions for the 7-segment digit decoder/sequencer.
//   - segment bit indices within a segments[6:0] bus
//   - 16-entry signed-digit table {N, segments}; the encoder uses the same
//     table so encode and decode directions cannot drift apart
//   - sequencer state enum
package seg7_pkg;

  localparam int unsigned SEG_TOP = 0;
  localparam int unsigned SEG_UR  = 1;
  localparam int unsigned SEG_LR  = 2;
  localparam int unsigned SEG_BOT = 3;
  localparam int unsigned SEG_LL  = 4;
  localparam int unsigned SEG_UL  = 5;
  localparam int unsigned SEG_MID = 6;

  // Indexed by the raw 4-bit two's-complement code; bit 7 is N (negative).
  // Negative codes show the magnitude glyph, -8 shows the full "8".
  localparam logic [15:0][7:0] SEG7_TABLE = {
    8'h86,  // F : -1
    8'hDB,  // E : -2
    8'hCF,  // D : -3
    8'hE6,  // C : -4
    8'hED,  // B : -5
    8'hFC,  // A : -6
    8'h87,  // 9 : -7
    8'hFF,  // 8 : -8
    8'h07,  // 7
    8'h7C,  // 6
    8'h6D,  // 5
    8'h66,  // 4
    8'h4F,  // 3
    8'h5B,  // 2
    8'h06,  // 1
    8'h3F   // 0
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2
  } seg7_state_e;

  function automatic logic [7:0] seg7_decode(input logic [3:0] code);
    return SEG7_TABLE[code];
  endfunction

endpackage

// File: rtl/seg7_dec_lut.sv
// seg7_dec_lut: combinational signed digit -> {N, segments} decoder.
//   code     : two's-complement digit, -8..7
//   n        : 1 when the digit is negative
//   segments : 7-segment pattern, 1 = lit
module seg7_dec_lut
  import seg7_pkg::*;
(
  input  logic [3:0] code,
  output logic       n,
  output logic [6:0] segments
);

  assign {n, segments} = seg7_decode(code);

endmodule

// File: rtl/seg7_dec_seq.sv
// seg7_dec_seq: streaming signed-digit to 7-segment sequencer.
// Digits enter a DEPTH-entry FIFO over valid/ready; each one is shown on
// {N, segments} for DWELL_CYCLES cycles followed by GAP_CYCLES blank cycles.
//   clk, rst_n : system clock, async active-low reset
//   in_digit   : two's-complement digit, -8..7
//   in_valid   : in_digit valid
//   in_ready   : FIFO can accept (not full, not clearing)
//   clear      : synchronous flush of FIFO and display
//   segments   : registered segment pattern, 1 = lit
//   N          : registered sign indicator
//   busy       : sequencer not idle
//   level      : FIFO occupancy
//
// state | meaning
// IDLE  | outputs blank, waiting for a digit in the FIFO
// SHOW  | digit on the outputs, dwell counter running
// GAP   | outputs blank, gap counter running
module seg7_dec_seq
  import seg7_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int DWELL_CYCLES = 1000,
  parameter int GAP_CYCLES   = 100
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [3:0]               in_digit,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     clear,
  output logic [6:0]               segments,
  output logic                     N,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW      = $clog2(DEPTH);
  localparam int LW      = AW + 1;
  localparam int MAX_CNT = (DWELL_CYCLES > GAP_CYCLES) ? DWELL_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

  localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;

  logic [3:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          full, empty, push, pop;

  logic [3:0]    head_code;
  logic          head_n;
  logic [6:0]    head_seg;

  seg7_state_e      state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [6:0]       seg_q, seg_n;
  logic             n_q, n_n;

  assign full     = (level == LW'(DEPTH));
  assign empty    = (level == '0);
  assign in_ready = !full && !clear;
  assign push     = in_valid && in_ready;

  assign head_code = mem[rd_ptr];

  seg7_dec_lut u_lut (
    .code     (head_code),
    .n        (head_n),
    .segments (head_seg)
  );

  // Storage carries no reset; only pointers and level define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_digit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      seg_q <= '0;
      n_q   <= 1'b0;
    end else if (clear) begin
      state <= IDLE;
      cnt   <= '0;
      seg_q <= '0;
      n_q   <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      seg_q <= seg_n;
      n_q   <= n_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    seg_n   = seg_q;
    n_n     = n_q;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        seg_n = '0;
        n_n   = 1'b0;
        if (!empty) begin
          pop     = 1'b1;
          seg_n   = head_seg;
          n_n     = head_n;
          cnt_n   = DWELL_LOAD;
          state_n = SHOW;
        end
      end
      SHOW: begin
        if (cnt != '0) begin
          cnt_n = cnt - 1'b1;
        end else if (GAP_CYCLES > 0) begin
          seg_n   = '0;
          n_n     = 1'b0;
          cnt_n   = GAP_LOAD;
          state_n = GAP;
        end else if (!empty) begin
          // back-to-back: next digit replaces the current one with no blank
          pop   = 1'b1;
          seg_n = head_seg;
          n_n   = head_n;
          cnt_n = DWELL_LOAD;
        end else begin
          seg_n   = '0;
          n_n     = 1'b0;
          state_n = IDLE;
        end
      end
      GAP: begin
        if (cnt != '0) begin
          cnt_n = cnt - 1'b1;
        end else if (!empty) begin
          pop     = 1'b1;
          seg_n   = head_seg;
          n_n     = head_n;
          cnt_n   = DWELL_LOAD;
          state_n = SHOW;
        end else begin
          state_n = IDLE;
        end
      end
      default: begin
        seg_n   = '0;
        n_n     = 1'b0;
        state_n = IDLE;
      end
    endcase
  end

  assign segments = seg_q;
  assign N        = n_q;
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_seg7_dec_seq.sv
// Testbench for seg7_dec_seq. Two instances: dut with DWELL=4/GAP=2 and
// dut0 with DWELL=4/GAP=0 for the back-to-back sweep.
module tb_seg7_dec_seq;

  localparam int DEPTH = 4;
  localparam int DWELL = 4;
  localparam int GAPC  = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] in_digit, in_digit0;
  logic       in_valid, in_valid0;
  logic       clear, clear0;
  logic       in_ready, in_ready0;
  logic [6:0] segments, segments0;
  logic       n_out, n_out0;
  logic       busy, busy0;
  logic [2:0] level, level0;

  always #5 clk = ~clk;

  seg7_dec_seq #(.DEPTH(DEPTH), .DWELL_CYCLES(DWELL), .GAP_CYCLES(GAPC)) dut (
    .clk(clk), .rst_n(rst_n), .in_digit(in_digit), .in_valid(in_valid),
    .in_ready(in_ready), .clear(clear), .segments(segments), .N(n_out),
    .busy(busy), .level(level)
  );

  seg7_dec_seq #(.DEPTH(DEPTH), .DWELL_CYCLES(DWELL), .GAP_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_digit(in_digit0), .in_valid(in_valid0),
    .in_ready(in_ready0), .clear(clear0), .segments(segments0), .N(n_out0),
    .busy(busy0), .level(level0)
  );

  int checks = 0;
  int passes = 0;

  // Reference: glyph for each magnitude 0..8; sign goes to N.
  logic [6:0] glyph [9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7C, 7'h07, 7'h7F};

  function automatic logic [7:0] exp_pat(input logic [3:0] code);
    int v, mag;
    v   = code[3] ? int'(code) - 16 : int'(code);
    mag = (v < 0) ? -v : v;
    return {(v < 0), glyph[mag]};
  endfunction

  // Encoder model: glyph -> magnitude, then apply sign.
  function automatic logic [3:0] enc(input logic [7:0] p);
    int mag;
    mag = 0;
    for (int i = 8; i >= 0; i--) if (glyph[i] == p[6:0]) mag = i;
    return p[7] ? 4'((16 - mag) & 15) : 4'(mag);
  endfunction

  // Run-length monitor on the selected instance's {N, segments}.
  typedef struct packed {
    logic [7:0] val;
    int         len;
  } run_t;

  run_t       runs [$];
  run_t       nb_q [$];
  int         gap_q [$];
  logic       mon_en = 1'b0;
  logic       mon_was_en = 1'b0;
  logic       mon_sel = 1'b0;
  logic [7:0] run_val;
  int         run_len = 0;

  always @(negedge clk) begin
    logic [7:0] cur;
    cur = mon_sel ? {n_out0, segments0} : {n_out, segments};
    if (mon_en && !mon_was_en) begin
      runs.delete();
      run_len = 0;
    end
    if (mon_en) begin
      if (run_len > 0 && cur == run_val) run_len++;
      else begin
        if (run_len > 0) runs.push_back('{run_val, run_len});
        run_val = cur;
        run_len = 1;
      end
    end else if (run_len > 0) begin
      runs.push_back('{run_val, run_len});
      run_len = 0;
    end
    mon_was_en = mon_en;
  end

  // Non-blank runs in order, and blank run lengths strictly between them.
  function automatic void split_runs();
    int first, last;
    nb_q.delete();
    gap_q.delete();
    first = -1;
    last  = -1;
    foreach (runs[i]) if (runs[i].val != 8'h00) begin
      if (first < 0) first = i;
      last = i;
    end
    if (first >= 0)
      for (int i = first; i <= last; i++)
        if (runs[i].val != 8'h00) nb_q.push_back(runs[i]);
        else gap_q.push_back(runs[i].len);
  endfunction

  task automatic stop_mon();
    mon_en = 1'b0;
    repeat (2) @(negedge clk);
    split_runs();
  endtask

  task automatic wait_idle(input int bound, input string name);
    int g;
    g = 0;
    while ((busy || level != 0 || busy0 || level0 != 0) && g < bound) begin
      @(negedge clk);
      g++;
    end
    checks++;
    if (g >= bound) $display("FAIL %s idle timeout: busy=%0b level=%0d after %0d cycles", name, busy, level, g);
    else passes++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clear = 1'b0; clear0 = 1'b0;
    in_valid = 1'b0; in_valid0 = 1'b0; in_digit = '0; in_digit0 = '0;
    #3;
    checks++; if (in_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", in_ready); else passes++;
    checks++; if (segments !== 7'h00) $display("FAIL reset_seg got %h want 00", segments); else passes++;
    checks++; if (n_out !== 1'b0) $display("FAIL reset_n got %b want 0", n_out); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passes++;
    checks++; if (level !== 3'd0) $display("FAIL reset_level got %0d want 0", level); else passes++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    in_digit = 4'h3; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (segments !== 7'h00 || level !== 3'd1)
      $display("FAIL single_e0 got seg=%h level=%0d want seg=00 level=1", segments, level); else passes++;
    for (int i = 0; i < DWELL; i++) begin
      @(negedge clk);
      checks++; if ({n_out, segments} !== exp_pat(4'h3) || busy !== 1'b1)
        $display("FAIL single_show%0d got %h busy=%b want %h busy=1", i, {n_out, segments}, busy, exp_pat(4'h3)); else passes++;
    end
    for (int i = 0; i < GAPC; i++) begin
      @(negedge clk);
      checks++; if ({n_out, segments} !== 8'h00 || busy !== 1'b1)
        $display("FAIL single_gap%0d got %h busy=%b want 00 busy=1", i, {n_out, segments}, busy); else passes++;
    end
    @(negedge clk);
    checks++; if (busy !== 1'b0 || {n_out, segments} !== 8'h00)
      $display("FAIL single_idle got busy=%b out=%h want busy=0 out=00", busy, {n_out, segments}); else passes++;
  endtask

  task automatic test_negative_pair();
    logic [7:0] exp_tr [10];
    logic [7:0] got;
    for (int i = 0; i < 10; i++) exp_tr[i] = 8'h00;
    for (int i = 0; i < DWELL; i++) begin
      exp_tr[i]             = exp_pat(4'h8);
      exp_tr[i + DWELL + GAPC] = exp_pat(4'hF);
    end
    in_digit = 4'h8; in_valid = 1'b1;
    @(negedge clk);
    in_digit = 4'hF;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      got = {n_out, segments};
      checks++; if (got !== exp_tr[i])
        $display("FAIL negpair_cyc%0d got %h want %h", i, got, exp_tr[i]); else passes++;
      if (i == 0) begin
        checks++; if (enc(got) !== 4'h8) $display("FAIL negpair_enc_m8 got %h want 8", enc(got)); else passes++;
      end
      if (i == DWELL + GAPC) begin
        checks++; if (enc(got) !== 4'hF) $display("FAIL negpair_enc_m1 got %h want F", enc(got)); else passes++;
      end
      @(negedge clk);
    end
    wait_idle(50, "negpair");
  endtask

  task automatic test_sweep_back_to_back();
    int k, g;
    mon_sel = 1'b1;
    mon_en  = 1'b1;
    k = 0; g = 0;
    while (k < 16 && g < 200) begin
      @(negedge clk);
      in_valid0 = 1'b1;
      in_digit0 = 4'(k);
      if (in_ready0) k++;
      g++;
    end
    @(negedge clk);
    in_valid0 = 1'b0;
    checks++; if (k != 16) $display("FAIL sweep_accept got %0d want 16", k); else passes++;
    wait_idle(200, "sweep");
    stop_mon();
    checks++; if (nb_q.size() != 16) $display("FAIL sweep_count got %0d want 16", nb_q.size()); else passes++;
    checks++; if (gap_q.size() != 0) $display("FAIL sweep_blank got %0d blank runs want 0", gap_q.size()); else passes++;
    foreach (nb_q[i]) begin
      checks++; if (nb_q[i].val !== exp_pat(4'(i)) || nb_q[i].len != DWELL)
        $display("FAIL sweep_digit%0d got %h x%0d want %h x%0d", i, nb_q[i].val, nb_q[i].len, exp_pat(4'(i)), DWELL); else passes++;
      checks++; if (enc(nb_q[i].val) !== 4'(i))
        $display("FAIL sweep_enc%0d got %h want %h", i, enc(nb_q[i].val), 4'(i)); else passes++;
    end
    mon_sel = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [3:0] expq [$];
    logic       took, saw_full;
    took = 1'b0; saw_full = 1'b0;
    mon_en = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (c == 0 || took) in_digit = 4'($urandom);
      in_valid = 1'b1;
      checks++; if (in_ready !== (level != 3'd4) || level > 3'd4)
        $display("FAIL bp_ready cyc%0d got ready=%b level=%0d want ready=%b", c, in_ready, level, (level != 3'd4)); else passes++;
      if (level == 3'd4) saw_full = 1'b1;
      took = in_ready;
      if (took) expq.push_back(in_digit);
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (!saw_full) $display("FAIL bp_full got level never 4 want 4"); else passes++;
    wait_idle(300, "bp");
    stop_mon();
    checks++; if (nb_q.size() != expq.size())
      $display("FAIL bp_count got %0d want %0d", nb_q.size(), expq.size()); else passes++;
    foreach (nb_q[i]) if (i < expq.size()) begin
      checks++; if (nb_q[i].val !== exp_pat(expq[i]) || nb_q[i].len != DWELL)
        $display("FAIL bp_digit%0d got %h x%0d want %h x%0d", i, nb_q[i].val, nb_q[i].len, exp_pat(expq[i]), DWELL); else passes++;
    end
    foreach (gap_q[i]) begin
      checks++; if (gap_q[i] != GAPC) $display("FAIL bp_gap%0d got %0d want %0d", i, gap_q[i], GAPC); else passes++;
    end
  endtask

  task automatic test_random();
    logic [3:0] expq [$];
    mon_en = 1'b1;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      in_valid = ($urandom_range(0, 3) == 0);
      in_digit = 4'($urandom);
      if (in_valid && in_ready) expq.push_back(in_digit);
    end
    @(negedge clk);
    in_valid = 1'b0;
    wait_idle(400, "rand");
    stop_mon();
    checks++; if (nb_q.size() != expq.size())
      $display("FAIL rand_count got %0d want %0d", nb_q.size(), expq.size()); else passes++;
    foreach (nb_q[i]) if (i < expq.size()) begin
      checks++; if (nb_q[i].val !== exp_pat(expq[i]) || nb_q[i].len != DWELL)
        $display("FAIL rand_digit%0d got %h x%0d want %h x%0d", i, nb_q[i].val, nb_q[i].len, exp_pat(expq[i]), DWELL); else passes++;
    end
    foreach (gap_q[i]) begin
      checks++; if (gap_q[i] < GAPC) $display("FAIL rand_gap%0d got %0d want >=%0d", i, gap_q[i], GAPC); else passes++;
    end
  endtask

  task automatic test_clear();
    logic [3:0] d [4];
    for (int i = 0; i < 4; i++) d[i] = 4'($urandom);
    mon_en = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      in_digit = d[i]; in_valid = 1'b1;
      @(negedge clk);
    end
    checks++; if (level !== 3'd3 || busy !== 1'b1)
      $display("FAIL clr_pre got level=%0d busy=%b want level=3 busy=1", level, busy); else passes++;
    clear = 1'b1;
    in_digit = 4'($urandom);
    #1;
    checks++; if (in_ready !== 1'b0) $display("FAIL clr_ready got %b want 0", in_ready); else passes++;
    @(negedge clk);
    checks++; if (level !== 3'd0 || {n_out, segments} !== 8'h00 || busy !== 1'b0)
      $display("FAIL clr_post got level=%0d out=%h busy=%b want 0/00/0", level, {n_out, segments}, busy); else passes++;
    clear = 1'b0; in_valid = 1'b0;
    repeat (10) @(negedge clk);
    checks++; if (level !== 3'd0 || busy !== 1'b0)
      $display("FAIL clr_later got level=%0d busy=%b want 0/0", level, busy); else passes++;
    stop_mon();
    checks++; if (nb_q.size() != 1) $display("FAIL clr_runs got %0d want 1", nb_q.size()); else passes++;
    if (nb_q.size() > 0) begin
      checks++; if (nb_q[0].val !== exp_pat(d[0]))
        $display("FAIL clr_shown got %h want %h", nb_q[0].val, exp_pat(d[0])); else passes++;
    end
  endtask

  task automatic test_async_reset();
    logic [3:0] d2;
    d2 = 4'($urandom);
    in_digit = 4'h5; in_valid = 1'b1;
    @(negedge clk);
    in_digit = 4'hA;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (DWELL) @(negedge clk);
    // first gap cycle
    checks++; if (busy !== 1'b1 || level !== 3'd1)
      $display("FAIL rst_pre got busy=%b level=%0d want 1/1", busy, level); else passes++;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || level !== 3'd0 || {n_out, segments} !== 8'h00)
      $display("FAIL rst_gap got busy=%b level=%0d out=%h want 0/0/00", busy, level, {n_out, segments}); else passes++;
    @(negedge clk);
    rst_n = 1'b1;
    in_digit = d2; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if ({n_out, segments} !== 8'h00 || level !== 3'd1)
      $display("FAIL rst_lat0 got out=%h level=%0d want 00/1", {n_out, segments}, level); else passes++;
    @(negedge clk);
    checks++; if ({n_out, segments} !== exp_pat(d2))
      $display("FAIL rst_lat1 got %h want %h", {n_out, segments}, exp_pat(d2)); else passes++;
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({n_out, segments} !== 8'h00 || busy !== 1'b0)
      $display("FAIL rst_show got out=%h busy=%b want 00/0", {n_out, segments}, busy); else passes++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single();
    test_negative_pair();
    test_sweep_back_to_back();
    test_backpressure();
    test_random();
    test_clear();
    test_async_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/seg7_dec_seq.md
Name: seg7_dec_seq

Overview:
Streaming signed-digit to 7-segment decoder/sequencer; the transmit-side counterpart of the segment-to-digit encoder.
- Accepts signed 4-bit digits (-8..7) over valid/ready into a small FIFO.
- Shows each digit on {N, segments} for a fixed dwell time, with an optional blank gap between digits so repeated values stay distinguishable.
- Sits between the test logic and the board 7-segment output pins.

Parameters:
DEPTH, 4, FIFO entries; power of 2, at least 2.
DWELL_CYCLES, 1000, cycles each digit is displayed; at least 1.
GAP_CYCLES, 100, blank cycles after each dwell; 0 means no gap state.

Ports:
clk  input  1  single system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_digit  input  4  two's-complement digit, -8..7
in_valid  input  1  in_digit valid
in_ready  output  1  FIFO can accept; equals !full && !clear
clear  input  1  synchronous flush of FIFO and display
segments  output  7  bit0=seg1 top, bit1=seg2 upper-right, bit2=seg3 lower-right, bit3=seg4 bottom, bit4=seg5 lower-left, bit5=seg6 upper-left, bit6=seg7 middle; 1=lit
N  output  1  sign indicator, 1 for negative digit
busy  output  1  FSM not in IDLE
level  output  $clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (rst_n low, async): FIFO empty, level=0, FSM=IDLE, segments=0, N=0, busy=0. in_ready follows full/clear combinationally, so it reads 1 while reset is held.
- Push: occurs on a rising edge with in_valid && in_ready. in_ready ignores a same-cycle pop, so the FIFO is never written when full.
- Decode is magnitude plus sign, exactly invertible by the team's encoder:
  - 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7C, 7=0x07; N=0 for these.
  - -1=0x06, -2=0x5B, -3=0x4F, -4=0x66, -5=0x6D, -6=0x7C, -7=0x07, -8=0x7F; N=1 for these.
  - No invalid codes exist.
- segments and N are registered.
- FSM states:
  - IDLE: segments=0, N=0. If FIFO is non-empty, pop the head, load the decoded value into the output registers, load the dwell counter with DWELL_CYCLES-1, and go to SHOW.
  - SHOW: hold the outputs and decrement the counter. At 0:
    - If GAP_CYCLES>0: blank the outputs, load the counter with GAP_CYCLES-1, go to GAP.
    - Else if FIFO is non-empty: pop and load the next digit, stay in SHOW (back-to-back, no blank cycle).
    - Else: blank the outputs, go to IDLE.
  - GAP: outputs blank. Decrement; at 0, same pop/IDLE decision as SHOW with GAP_CYCLES=0.
- Latency:
  - Digit accepted at edge E into an empty FIFO while in IDLE: pattern visible after edge E+1.
  - Each digit is visible for exactly DWELL_CYCLES cycles; blank for exactly GAP_CYCLES cycles.
- Simultaneous push and pop: both take effect and level is unchanged.
- Push into an empty FIFO while the FSM pops: impossible, because pop requires non-empty at the edge.
- clear (synchronous, highest priority after reset):
  - Empties the FIFO (level=0), FSM to IDLE, segments=0, N=0.
  - in_ready=0 during clear; a concurrent push is dropped.
- Pointers wrap modulo DEPTH. level is kept as an explicit counter or as a pointer difference with an extra MSB.
- Reset asserted mid-display: immediate blank; no partial digit resumes.

Decomposition:
- Shared package seg7_pkg holds:
  - segment bit-index constants SEG_TOP..SEG_MID;
  - the 16-entry digit-to-segment constant table, shared with the encoder's case list so the two directions cannot diverge;
  - the FSM state enum (IDLE, SHOW, GAP).
- One sub-module, seg7_dec_lut: combinational in_digit[3:0] to {N, segments[6:0]}, instantiated once on the FIFO head.
- FIFO and FSM stay in seg7_dec_seq.

Test Plan:
- Reset, then push 3 (0x3) with DWELL=4, GAP=2 -> after edge E+1: segments=0x4F, N=0 for 4 cycles; blank 2 cycles; then IDLE with busy=0.
- Push -8 (0x8), then -1 (0xF) -> 0x7F/N=1 for 4 cycles, blank 2, then 0x06/N=1 for 4 cycles. The encoder fed these outputs returns 0x8 and 0xF.
- Sweep all 16 digits with GAP_CYCLES=0 -> back-to-back patterns with no blank cycle between them; each {N, segments} matches the table and round-trips through the encoder.
- Hold in_valid with DEPTH=4 while displaying -> in_ready drops when level=4; no push while full; in_ready rises the cycle after the next pop; no digit is lost or duplicated.
- Assert clear mid-SHOW with level=3 while in_valid=1 -> next edge: level=0, segments=0, N=0, busy=0; the concurrent digit is never displayed.
- Pulse rst_n low asynchronously mid-GAP -> outputs 0 immediately without waiting for a clock edge; after release, the first push displays normally with latency 1.
